// File: rtl/db3_2_gen.sv
// Back-propagation delta for output neuron 3_2, batch-accumulated into a bias step.
// Valid/ready: valid_in qualifies a3_2/t3_2 for one cycle each; there is no backpressure.
module db3_2_gen #(
    parameter int BATCH    = 4,
    parameter int LR_SHIFT = 2,
    parameter int ACC_W    = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [15:0] a3_2,
    input  logic [15:0] t3_2,
    input  logic        flush,
    output logic [15:0] db3_2,
    output logic        update,
    output logic        busy,
    output logic [7:0]  count
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   POS16   = 32767;
    localparam logic signed [ACC_W:0]   NEG16   = -32768;
    localparam logic [7:0]              BATCH_C = 8'(BATCH);

    function automatic logic signed [15:0] sat16(input logic signed [32:0] x);
        if (x > 33'sd32767)       return 16'sh7fff;
        else if (x < -33'sd32768) return 16'sh8000;
        else                      return x[15:0];
    endfunction

    logic               v1, v2, v3;
    logic signed [16:0] e1, oma1, e2;
    logic signed [15:0] a1, p2, d3;
    logic signed [ACC_W-1:0] acc;
    logic               flush_pend;

    logic signed [32:0]    prod_ao, prod_ep;
    logic signed [ACC_W:0] acc_sum;
    logic signed [ACC_W-1:0] acc_add, acc_shift;
    logic signed [ACC_W:0] neg;
    logic [15:0]           db_next;
    logic [7:0]            count_add;
    logic                  full, flush_fire, emit;

    assign busy = v1 | v2 | v3;

    always_comb begin
        // Operands are pre-extended to the product width so the low 33 bits are exact.
        prod_ao = {{17{a1[15]}}, a1} * {{16{oma1[16]}}, oma1};
        prod_ep = {{16{e2[16]}}, e2} * {{17{p2[15]}}, p2};

        acc_sum = {acc[ACC_W-1], acc} + {{(ACC_W+1-16){d3[15]}}, d3};
        acc_add = acc;
        if (v3) begin
            if (acc_sum[ACC_W] != acc_sum[ACC_W-1])
                acc_add = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
            else
                acc_add = acc_sum[ACC_W-1:0];
        end
        count_add = v3 ? count + 8'd1 : count;

        full       = v3 && (count_add == BATCH_C);
        flush_fire = flush_pend && !busy && !v3;
        emit       = full || (flush_fire && (count != 8'd0));

        acc_shift = acc_add >>> LR_SHIFT;
        neg       = -{acc_shift[ACC_W-1], acc_shift};
        if (neg > POS16)      db_next = 16'h7fff;
        else if (neg < NEG16) db_next = 16'h8000;
        else                  db_next = neg[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            e1         <= '0;
            oma1       <= '0;
            a1         <= '0;
            e2         <= '0;
            p2         <= '0;
            d3         <= '0;
            acc        <= '0;
            count      <= '0;
            db3_2      <= '0;
            update     <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            v1 <= valid_in;
            if (valid_in) begin
                e1   <= {a3_2[15], a3_2} - {t3_2[15], t3_2};
                oma1 <= 17'sh00400 - {a3_2[15], a3_2};
                a1   <= a3_2;
            end

            v2 <= v1;
            if (v1) begin
                p2 <= sat16(prod_ao >>> 10);
                e2 <= e1;
            end

            v3 <= v2;
            if (v2)
                d3 <= sat16(prod_ep >>> 10);

            update <= emit;
            if (emit) begin
                db3_2 <= db_next;
                acc   <= '0;
                count <= '0;
            end else begin
                acc   <= acc_add;
                count <= count_add;
            end

            // A flush seen on the firing cycle stays pending and applies to the new batch.
            flush_pend <= flush || (flush_pend && !flush_fire);
        end
    end

endmodule

// File: doc/db3_2_gen.md
Name: db3_2_gen

Overview:
- Upstream feeder of the output-layer bias-2 update register. It consumes the output-neuron activation a3_2 and target t3_2.
- It computes the back-propagation delta delta3_2 = (a3_2 - t3_2) * a3_2 * (1 - a3_2) in a 3-stage pipeline.
- It accumulates deltas over a mini-batch, then issues db3_2 = -(sum >>> LR_SHIFT) together with a one-cycle update strobe.
- The strobe drives select_update of the bias register directly.

Parameters:
- BATCH, 4, samples per update; legal range 1..255.
- LR_SHIFT, 2, learning rate = 2^-LR_SHIFT; legal range 0..15.
- ACC_W, 24, accumulator width in bits (signed).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- valid_in  input  1  a3_2/t3_2 are valid this cycle; one sample per cycle, no backpressure.
- a3_2  input  16  activation; signed fixed-point, 6 integer bits (incl. sign) + 10 fraction bits (1.0 = 0x0400).
- t3_2  input  16  target; same format as a3_2.
- flush  input  1  force an update from a partial batch.
- db3_2  output  16  delta bias; same format as a3_2; held between updates.
- update  output  1  one-cycle strobe; db3_2 is valid while update is high.
- busy  output  1  high while any pipeline stage holds a valid sample.
- count  output  8  samples accumulated in the current batch.

Behaviour:
- Reset, synchronous: all pipeline valids cleared; accumulator = 0; count = 0; db3_2 = 0x0000; update = 0; busy = 0. Reset mid-pipeline discards in-flight samples. A flush pending during reset is dropped.
- S1, the cycle after valid_in:
  - e = a3_2 - t3_2, 17-bit signed.
  - oma = 0x0400 - a3_2, 17-bit signed.
  - a3_2 is registered.
- S2:
  - p = (a3_2 * oma) >>> 10, arithmetic shift (floor).
  - p saturates to [-32768, 32767].
- S3:
  - d = (e * p) >>> 10, floor.
  - d saturates to 16 bits.
  - A valid d is presented to the accumulator.
- Accumulate, on the cycle d is valid:
  - acc_next = acc + sign_extend(d), saturating at ACC_W limits.
  - count increments.
  - Sample accepted at cycle N is summed into acc at the clock edge ending cycle N+3.
- Emit condition: when count reaches BATCH (including the sample just added), the emit happens that edge.
  - db3_2 = saturate16(-(acc_next >>> LR_SHIFT)).
  - update = 1 for exactly one cycle.
  - acc and count are cleared.
- Flush:
  - flush is registered as pending.
  - Once busy = 0 and no S3 sample is valid, if count > 0, emit as above with the partial sum, then clear pending.
  - If count = 0, clear pending and emit nothing.
  - Samples arriving with or after flush, before pipeline drain, are included in the flushed batch.
- Simultaneous events:
  - valid_in on the emit cycle enters S1 normally and belongs to the next batch.
  - flush asserted while a full-batch emit occurs: the full batch is emitted; the flush then applies to the (empty) new batch and does nothing.
- Saturation: -(-32768) saturates to +32767. No wrap-around anywhere.
- update never asserts on consecutive cycles when BATCH = 1? It may: BATCH = 1 with back-to-back valid_in gives update every cycle, each strobe with its own db3_2.
- busy = OR of S1..S3 valids; count is the registered value.
- Downstream requirement: the bias register receives db3_2 and update directly. Its select_initial is asserted only while update = 0; this block does not gate it.

Test Plan:
1. BATCH=1, LR_SHIFT=2; a3_2=0x0300, t3_2=0x0400 for one cycle.
   -> e=-256, p=192, d=-48.
   -> exactly 4 cycles after valid_in, update=1 for one cycle with db3_2=0x000C (+12).
2. BATCH=4, LR_SHIFT=2; four consecutive samples a3_2=0x0200, t3_2=0x0000.
   -> d=128 each; count steps 1..4; acc=512.
   -> update once, 4 cycles after the 4th sample, db3_2=0xFF80 (-128); count returns to 0.
3. Floor rounding: BATCH=1, LR_SHIFT=5; sample from scenario 1.
   -> -48>>>5 = -2; db3_2=0x0002.
4. Saturation: BATCH=1, LR_SHIFT=0; a3_2=0x7FFF, t3_2=0x0000.
   -> p saturates to -32768; d saturates to -32768; db3_2=0x7FFF.
5. Flush: BATCH=4; two samples of scenario 2, then flush in the cycle after the 2nd.
   -> update once after drain with db3_2=0xFFC0 (-64).
   -> flush with count=0 and an idle pipeline -> no update.
6. Reset mid-operation: three samples issued; reset asserted while the 3rd is in S2.
   -> db3_2=0, count=0, busy=0 the cycle after reset.
   -> a fresh 4-sample batch afterwards gives exactly scenario 2's result.
